// File: rtl/axi4_uart_rx_bridge.sv
// ---------------------------------------------------------------------------
// axi4_uart_rx_bridge
//   UART receiver (16x oversampled) with a byte FIFO that is read through
//   an AXI4-Lite read-only slave (AR/R channels).
//
//   Registers (only araddr[31:2] is decoded):
//     BASE_ADDR     DATA   : {23'b0, valid, byte}; popping read, 0 when empty
//     BASE_ADDR + 4 STATUS : [0] not empty  [1] full  [2] OVERRUN
//                            [3] FRAME_ERR  [4] busy  [5] PARITY_ERR
//                            [16:8] FIFO count; read clears the sticky errors
//     other                : rdata 0, rresp SLVERR, no side effects
//
//   Ports:
//     clk, rst               clock, asynchronous active-low reset
//     axi_ar*, axi_r*        AXI4-Lite read address / read data channels
//     uart_rx                serial input (idle high, asynchronous)
//     uart_rx_busy           a frame is in progress
//     rx_irq                 FIFO non-empty or any sticky error set
//
//   Optional build macro: UART_RX_PARITY_EN -> 8E1 frames with a PARITY
//   state; a parity mismatch sets PARITY_ERR and drops the byte.
// ---------------------------------------------------------------------------
module axi4_uart_rx_bridge #(
    parameter int unsigned CLK_DIV    = 78,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    input  logic        uart_rx,
    output logic        uart_rx_busy,
    output logic        rx_irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

    // ---------------- input synchronizer ----------------
    logic rx_meta, rx_s;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------- oversample prescaler ----------------
    logic [PW-1:0] presc;
    logic          tick;
    assign tick = (presc == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // ---------------- receive FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t     state;
    logic [3:0] os_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bad;
    logic       push_req;   // one-cycle strobe: shreg holds a good byte
    logic       ferr_set;
    logic       perr_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            os_cnt       <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bad      <= 1'b0;
            push_req     <= 1'b0;
            ferr_set     <= 1'b0;
            perr_set     <= 1'b0;
            uart_rx_busy <= 1'b0;
        end else begin
            push_req <= 1'b0;
            ferr_set <= 1'b0;
            perr_set <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state        <= S_START;
                            os_cnt       <= '0;
                            uart_rx_busy <= 1'b1;
                        end
                    end
                    S_START: begin
                        // Re-check the line half a bit in; a high level
                        // means the falling edge was noise.
                        if (os_cnt == 4'd7) begin
                            if (rx_s) begin
                                state        <= S_IDLE;
                                uart_rx_busy <= 1'b0;
                            end else begin
                                state   <= S_DATA;
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                                par_bad <= 1'b0;
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (os_cnt == 4'd15) begin
                            os_cnt  <= '0;
                            shreg   <= {rx_s, shreg[7:1]};   // LSB first
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (os_cnt == 4'd15) begin
                            os_cnt <= '0;
                            state  <= S_STOP;
                            // Even parity: data bits plus parity bit XOR to 0.
                            if ((^shreg) != rx_s) begin
                                par_bad  <= 1'b1;
                                perr_set <= 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (os_cnt == 4'd15) begin
                            os_cnt <= '0;
                            if (rx_s) begin
                                state        <= S_IDLE;
                                uart_rx_busy <= 1'b0;
                                push_req     <= !par_bad;
                            end else begin
                                ferr_set <= 1'b1;
                                state    <= S_BREAK;
                            end
                        end else begin
                            os_cnt <= os_cnt + 4'd1;
                        end
                    end
                    S_BREAK: begin
                        // Hold off new start detection until the line idles.
                        if (rx_s) begin
                            state        <= S_IDLE;
                            uart_rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        uart_rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- AXI decode ----------------
    logic ar_hs, is_data, is_stat, pop, stat_clr;
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^axi_araddr[1:0];
    assign axi_arready = !axi_rvalid;
    assign ar_hs    = axi_arvalid && axi_arready;
    assign is_data  = (axi_araddr[31:2] == BASE_ADDR[31:2]);
    assign is_stat  = (axi_araddr[31:2] == STAT_ADDR[31:2]);

    // ---------------- receive FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, do_push;
    logic [8:0]    count9;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = ar_hs && is_data && !empty;
    assign stat_clr = ar_hs && is_stat;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push_req && (!full || pop);
    assign count9   = 9'(count);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- sticky errors (set beats clear) ----------------
    logic ovr, ferr, perr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            perr <= 1'b0;
        end else begin
            ovr  <= (ovr  && !stat_clr) || (push_req && full && !pop);
            ferr <= (ferr && !stat_clr) || ferr_set;
            perr <= (perr && !stat_clr) || perr_set;
        end
    end

    assign rx_irq = !empty || ovr || ferr || perr;

    // ---------------- read response ----------------
    logic [31:0] status_word;
    assign status_word = {15'b0, count9, 2'b0, perr, uart_rx_busy, ferr, ovr, full, !empty};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= 2'b00;
        end else if (ar_hs) begin
            axi_rvalid <= 1'b1;
            if (is_data) begin
                axi_rdata <= empty ? 32'd0 : {23'b0, 1'b1, mem[rd_ptr]};
                axi_rresp <= 2'b00;
            end else if (is_stat) begin
                axi_rdata <= status_word;
                axi_rresp <= 2'b00;
            end else begin
                axi_rdata <= '0;
                axi_rresp <= 2'b10;
            end
        end else if (axi_rvalid && axi_rready) begin
            axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_uart_rx_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4_uart_rx_bridge
//   Directed bench for axi4_uart_rx_bridge with CLK_DIV=4 (64 clk per bit).
//   All stimulus changes 1 ns after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_axi4_uart_rx_bridge;

    localparam int BIT = 64;
    localparam logic [31:0] DATA_A = 32'h9000_0000;
    localparam logic [31:0] STAT_A = 32'h9000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [31:0] axi_araddr, axi_rdata;
    logic [1:0]  axi_rresp;
    logic        uart_rx, uart_rx_busy, rx_irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic [1:0]  rr;

    always #5 clk = ~clk;

    axi4_uart_rx_bridge #(.CLK_DIV(4), .FIFO_DEPTH(16), .BASE_ADDR(32'h9000_0000)) dut (
        .clk(clk), .rst(rst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp),
        .uart_rx(uart_rx), .uart_rx_busy(uart_rx_busy), .rx_irq(rx_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            clks(BIT);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = ^b;
        clks(BIT);
`endif
        uart_rx = stop_bit;
        clks(BIT);
        uart_rx = 1'b1;
        clks(BIT);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        axi_arvalid = 1'b1;
        axi_araddr  = addr;
        axi_rready  = 1'b1;
        n = 0;
        while (!axi_arready && n < 20) begin clks(1); n++; end
        clks(1);
        axi_arvalid = 1'b0;
        n = 0;
        while (!axi_rvalid && n < 20) begin clks(1); n++; end
        chk("rvalid_seen", {31'b0, axi_rvalid}, 32'd1);
        data = axi_rdata;
        resp = axi_rresp;
        clks(1);
    endtask

    initial begin
        rst = 1'b0; uart_rx = 1'b1;
        axi_arvalid = 1'b0; axi_araddr = '0; axi_rready = 1'b0;
        clks(3);
        chk("rst_arready", {31'b0, axi_arready},  32'd1);
        chk("rst_rvalid",  {31'b0, axi_rvalid},   32'd0);
        chk("rst_rdata",   axi_rdata,             32'd0);
        chk("rst_rresp",   {30'b0, axi_rresp},    32'd0);
        chk("rst_busy",    {31'b0, uart_rx_busy}, 32'd0);
        chk("rst_irq",     {31'b0, rx_irq},       32'd0);
        rst = 1'b1;
        clks(4);

        // Single frame 0xA5
        send_byte(8'hA5, 1'b1);
        chk("a5_irq", {31'b0, rx_irq}, 32'd1);
        axi_read(DATA_A, rd, rr);
        chk("a5_data", rd, 32'h0000_01A5);
        chk("a5_resp", {30'b0, rr}, 32'd0);
        axi_read(DATA_A, rd, rr);
        chk("empty_data", rd, 32'd0);
        chk("empty_irq", {31'b0, rx_irq}, 32'd0);

        // Start-bit glitch of 16 clk
        uart_rx = 1'b0;
        clks(16);
        uart_rx = 1'b1;
        clks(BIT);
        chk("glitch_busy", {31'b0, uart_rx_busy}, 32'd0);
        axi_read(STAT_A, rd, rr);
        chk("glitch_status", rd, 32'd0);

        // Framing error
        send_byte(8'h3C, 1'b0);
        chk("ferr_irq", {31'b0, rx_irq}, 32'd1);
        axi_read(STAT_A, rd, rr);
        chk("ferr_status", rd, 32'h0000_0008);
        axi_read(STAT_A, rd, rr);
        chk("ferr_cleared", rd, 32'd0);

        // Overrun: 17 bytes into a 16-entry FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        axi_read(STAT_A, rd, rr);
        chk("ovr_status", rd, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            axi_read(DATA_A, rd, rr);
            chk($sformatf("ovr_data%0d", i), rd, 32'h100 + 32'(i));
        end
        axi_read(DATA_A, rd, rr);
        chk("ovr_drained", rd, 32'd0);
        axi_read(STAT_A, rd, rr);
        chk("ovr_status_clr", rd, 32'd0);

        // Bad address and R-channel backpressure
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        axi_read(32'h9000_0008, rd, rr);
        chk("bad_resp", {30'b0, rr}, 32'h2);
        chk("bad_data", rd, 32'd0);
        axi_read(32'h9000_0007, rd, rr);   // low address bits ignored
        chk("lsb_status", rd, 32'h0000_0201);
        axi_rready  = 1'b0;
        axi_arvalid = 1'b1;
        axi_araddr  = DATA_A;
        clks(1);
        axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_rvalid%0d", i),  {31'b0, axi_rvalid},  32'd1);
            chk($sformatf("hold_rdata%0d", i),   axi_rdata,            32'h0000_0111);
            chk($sformatf("hold_arready%0d", i), {31'b0, axi_arready}, 32'd0);
            clks(1);
        end
        axi_rready = 1'b1;
        clks(1);
        chk("hold_done_rvalid", {31'b0, axi_rvalid}, 32'd0);
        chk("hold_done_arready", {31'b0, axi_arready}, 32'd1);
        axi_read(STAT_A, rd, rr);
        chk("hold_one_pop", rd, 32'h0000_0101);
        axi_read(DATA_A, rd, rr);
        chk("hold_next", rd, 32'h0000_0122);

        // Reset mid-frame with bytes queued
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        uart_rx = 1'b0;
        clks(BIT);
        uart_rx = 1'b1;
        clks(BIT / 2);
        chk("mid_busy", {31'b0, uart_rx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",    {31'b0, uart_rx_busy}, 32'd0);
        chk("mid_rst_irq",     {31'b0, rx_irq},       32'd0);
        chk("mid_rst_arready", {31'b0, axi_arready},  32'd1);
        chk("mid_rst_rvalid",  {31'b0, axi_rvalid},   32'd0);
        chk("mid_rst_rdata",   axi_rdata,             32'd0);
        clks(3);
        rst = 1'b1;
        clks(BIT);
        axi_read(STAT_A, rd, rr);
        chk("post_rst_status", rd, 32'd0);
        send_byte(8'h5A, 1'b1);
        axi_read(DATA_A, rd, rr);
        chk("post_rst_data", rd, 32'h0000_015A);
        axi_read(STAT_A, rd, rr);
        chk("post_rst_empty", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
